sdram_arbiter: RTL and testbench



---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_arb_pick.sv | 52 +++++
 rtl/sdram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDRAM requester arbiter.
//   - Controller command codes (2-bit cmd_req encoding).
//   - Arbiter FSM state encoding.
//   - Default read burst length.
//   Build option: SDRAM_ARB_FIXED_PRIO_EN (see sdram_arb_pick / sdram_arbiter).
// -----------------------------------------------------------------------------
package sdram_pkg;

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_WRB = 2'b01;
  localparam logic [1:0] CMD_WRW = 2'b11;
  localparam logic [1:0] CMD_RD  = 2'b10;

  localparam int BL_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// -----------------------------------------------------------------------------
// sdram_arb_pick
//   Combinational winner selection among pending requesters.
//   Ports:
//     req_vec   in   NPORT   one bit per requester, 1 = command pending
//     ptr       in   PW      last granted port (round-robin build only)
//     win_idx   out  PW      index of the selected requester
//     any_valid out  1       at least one requester is pending
//   Build option SDRAM_ARB_FIXED_PRIO_EN:
//     defined   -> lowest index wins, no pointer port
//     undefined -> search starts at ptr+1 and wraps to 0
// -----------------------------------------------------------------------------
module sdram_arb_pick #(
  parameter int NPORT = 3,
  parameter int PW    = 2
) (
  input  logic [NPORT-1:0] req_vec,
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  input  logic [PW-1:0]    ptr,
`endif
  output logic [PW-1:0]    win_idx,
  output logic             any_valid
);

  always_comb begin
    int cand;
    cand      = 0;
    win_idx   = '0;
    any_valid = 1'b0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    // Walk from highest to lowest so the lowest pending index is written last.
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_idx   = PW'(i);
        any_valid = 1'b1;
      end
    end
`else
    // Walk the rotated order backwards: the candidate closest after ptr is
    // written last and therefore wins. k = NPORT lands on ptr itself, so the
    // last-granted port only wins when nobody else is pending.
    for (int k = NPORT; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NPORT;
      if (req_vec[cand]) begin
        win_idx   = PW'(cand);
        any_valid = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Shares one SDRAM controller command port between NPORT requesters.
//   A pending request is picked in IDLE, registered onto mem_*, held until the
//   controller acks, and for reads the BL data beats are steered back to the
//   owning port only.
//   Ports:
//     clk, reset         clock / synchronous active-high reset
//     rq_req/mask/addr/din  packed per-port command (port p at slice p)
//     rq_ack             one-hot accept pulse to the owner (follows mem_ack)
//     rq_dout/rq_valid   read data broadcast, one-hot beat qualifier
//     mem_req/mask/addr/din  registered command to the controller
//     mem_ack, mem_dout, mem_valid  controller responses
//   Build option SDRAM_ARB_FIXED_PRIO_EN: fixed priority (port 0 highest)
//   instead of round-robin; the round-robin pointer is then not built.
// -----------------------------------------------------------------------------
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int ADDR_W = 32,
  parameter int BL     = BL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NPORT-1:0]    rq_req,
  input  logic [2*NPORT-1:0]    rq_mask,
  input  logic [ADDR_W*NPORT-1:0] rq_addr,
  input  logic [16*NPORT-1:0]   rq_din,
  output logic [NPORT-1:0]      rq_ack,
  output logic [15:0]           rq_dout,
  output logic [NPORT-1:0]      rq_valid,
  output logic [1:0]            mem_req,
  output logic [1:0]            mem_mask,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [15:0]           mem_din,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_dout,
  input  logic                  mem_valid
);

  localparam int PW = $clog2(NPORT);
  localparam int BW = $clog2(BL + 1);

  state_t            state_q,    state_d;
  logic [1:0]        mem_req_q,  mem_req_d;
  logic [1:0]        mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_din_q,  mem_din_d;
  logic [PW-1:0]     owner_q,    owner_d;
  logic [BW-1:0]     beat_q,     beat_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic [PW-1:0]     ptr_q,      ptr_d;
`endif

  logic [NPORT-1:0]  req_vec;
  logic [PW-1:0]     win_idx;
  logic              any_valid;
  int                sel;
  logic              ack_ok;
  logic              valid_ok;

  // Any nonzero command slice counts as a pending request.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_req
    assign req_vec[gi] = |rq_req[2*gi +: 2];
  end

  sdram_arb_pick #(
    .NPORT (NPORT),
    .PW    (PW)
  ) u_pick (
    .req_vec   (req_vec),
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    .ptr       (ptr_q),
`endif
    .win_idx   (win_idx),
    .any_valid (any_valid)
  );

  assign sel = int'(win_idx);

  // State register (FSM state plus the command / bookkeeping it owns).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= CMD_NOP;
      mem_mask_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      owner_q    <= '0;
      beat_q     <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q      <= PW'(NPORT - 1);
`endif
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_mask_q <= mem_mask_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_mask_d = mem_mask_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    owner_d    = owner_q;
    beat_d     = beat_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          mem_req_d  = rq_req[2*sel +: 2];
          mem_mask_d = rq_mask[2*sel +: 2];
          mem_addr_d = rq_addr[ADDR_W*sel +: ADDR_W];
          mem_din_d  = rq_din[16*sel +: 16];
          owner_d    = win_idx;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // mem_req_q still holds the command on the ack edge, so it decides
        // whether a data phase follows.
        if (mem_ack) begin
          mem_req_d = CMD_NOP;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
          ptr_d     = owner_q;
`endif
          if (mem_req_q == CMD_RD) begin
            state_d = ST_RDATA;
            beat_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RDATA: begin
        if (mem_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(BL - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: responses are only forwarded in the phase that expects them.
  always_comb begin
    ack_ok   = 1'b0;
    valid_ok = 1'b0;
    if (state_q == ST_ISSUE) begin
      ack_ok = mem_ack;
    end
    if (state_q == ST_RDATA) begin
      valid_ok = mem_valid;
    end
  end

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_resp
    assign rq_ack[gi]   = ack_ok   && (owner_q == PW'(gi));
    assign rq_valid[gi] = valid_ok && (owner_q == PW'(gi));
  end

  assign rq_dout  = mem_dout;
  assign mem_req  = mem_req_q;
  assign mem_mask = mem_mask_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed bench for sdram_arbiter (NPORT=3, ADDR_W=32, BL=4). The bench
//   plays the SDRAM controller by driving mem_ack / mem_valid / mem_dout.
//   Inputs change 1 time unit after a rising edge; outputs are checked on the
//   falling edge. Expectations switch on SDRAM_ARB_FIXED_PRIO_EN.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

  localparam int NPORT  = 3;
  localparam int ADDR_W = 32;
  localparam int BL     = 4;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [2*NPORT-1:0]      rq_req;
  logic [2*NPORT-1:0]      rq_mask;
  logic [ADDR_W*NPORT-1:0] rq_addr;
  logic [16*NPORT-1:0]     rq_din;
  logic [NPORT-1:0]        rq_ack;
  logic [15:0]             rq_dout;
  logic [NPORT-1:0]        rq_valid;
  logic [1:0]              mem_req;
  logic [1:0]              mem_mask;
  logic [ADDR_W-1:0]       mem_addr;
  logic [15:0]             mem_din;
  logic                    mem_ack;
  logic [15:0]             mem_dout;
  logic                    mem_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NPORT  (NPORT),
    .ADDR_W (ADDR_W),
    .BL     (BL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rq_req    (rq_req),
    .rq_mask   (rq_mask),
    .rq_addr   (rq_addr),
    .rq_din    (rq_din),
    .rq_ack    (rq_ack),
    .rq_dout   (rq_dout),
    .rq_valid  (rq_valid),
    .mem_req   (mem_req),
    .mem_mask  (mem_mask),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_ack   (mem_ack),
    .mem_dout  (mem_dout),
    .mem_valid (mem_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_port(input int p, input logic [1:0] req, input logic [1:0] mask,
                          input logic [31:0] addr, input logic [15:0] din);
    rq_req[2*p +: 2]   = req;
    rq_mask[2*p +: 2]  = mask;
    rq_addr[32*p +: 32] = addr;
    rq_din[16*p +: 16] = din;
  endtask

  // Drive n read beats, one per cycle, checking steering and data.
  task automatic beats(input int n, input logic [2:0] exp_v, input string tag);
    logic [15:0] exp_d;
    for (int i = 0; i < n; i++) begin
      exp_d     = 16'hB000 + 16'(i);
      mem_valid = 1'b1;
      mem_dout  = 16'hB000 + 16'(i);
      @(negedge clk);
      chk({tag, "_valid"}, 32'(rq_valid), 32'(exp_v));
      chk({tag, "_dout"},  32'(rq_dout),  32'(exp_d));
      tick();
    end
    mem_valid = 1'b0;
  endtask

  // A stray mem_valid must not reach any port while idle.
  task automatic probe_idle(input string tag);
    mem_valid = 1'b1;
    mem_dout  = 16'hEEEE;
    @(negedge clk);
    chk(tag, 32'(rq_valid), 32'h0);
    tick();
    mem_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_v;
    int         exp_p;

    reset     = 1'b1;
    rq_req    = '0;
    rq_mask   = '0;
    rq_addr   = '0;
    rq_din    = '0;
    mem_ack   = 1'b0;
    mem_dout  = '0;
    mem_valid = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req",   32'(mem_req),  32'h0);
    chk("rst_mask",  32'(mem_mask), 32'h0);
    chk("rst_addr",  mem_addr,      32'h0);
    chk("rst_din",   32'(mem_din),  32'h0);
    chk("rst_ack",   32'(rq_ack),   32'h0);
    chk("rst_valid", 32'(rq_valid), 32'h0);
    tick();
    reset = 1'b0;

    // 1. Single read, port 1
    set_port(1, 2'b10, 2'b00, 32'h0000_2000, 16'h0);
    @(negedge clk);
    chk("t1_pre", 32'(mem_req), 32'h0);
    tick();
    @(negedge clk);
    chk("t1_req",  32'(mem_req), 32'h2);
    chk("t1_addr", mem_addr,     32'h0000_2000);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t1_hold", 32'(mem_req), 32'h2);
    chk("t1_ack",  32'(rq_ack),  32'h2);
    tick();
    mem_ack = 1'b0;
    set_port(1, 2'b00, 2'b00, 32'h0, 16'h0);
    @(negedge clk);
    chk("t1_clr",    32'(mem_req), 32'h0);
    chk("t1_ackclr", 32'(rq_ack),  32'h0);
    tick();
    beats(4, 3'b010, "t1");
    probe_idle("t1_idle");

    // 2. Write word, port 0
    set_port(0, 2'b11, 2'b00, 32'h0000_0100, 16'hA55A);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t2_req",  32'(mem_req),  32'h3);
    chk("t2_din",  32'(mem_din),  32'hA55A);
    chk("t2_mask", 32'(mem_mask), 32'h0);
    chk("t2_ack",  32'(rq_ack),   32'h1);
    tick();
    mem_ack = 1'b0;
    set_port(0, 2'b00, 2'b00, 32'h0, 16'h0);
    @(negedge clk);
    chk("t2_after", 32'(mem_req), 32'h0);
    chk("t2_ackoff", 32'(rq_ack), 32'h0);
    tick();

    // 4. Port 2 write byte arrives while port 0 read data streams
    set_port(0, 2'b10, 2'b00, 32'h0000_3000, 16'h0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t4_rd",  32'(mem_req), 32'h2);
    chk("t4_ack", 32'(rq_ack),  32'h1);
    tick();
    mem_ack = 1'b0;
    set_port(0, 2'b00, 2'b00, 32'h0, 16'h0);
    set_port(2, 2'b01, 2'b10, 32'h0000_4000, 16'h00BB);
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1;
      mem_dout  = 16'hC000 + 16'(i);
      @(negedge clk);
      chk("t4_valid",   32'(rq_valid), 32'h1);
      chk("t4_nogrant", 32'(mem_req),  32'h0);
      tick();
    end
    mem_valid = 1'b0;
    @(negedge clk);
    chk("t4_idle", 32'(mem_req), 32'h0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t4_wrb",   32'(mem_req),  32'h1);
    chk("t4_mask",  32'(mem_mask), 32'h2);
    chk("t4_addr",  mem_addr,      32'h0000_4000);
    chk("t4_wrack", 32'(rq_ack),   32'h4);
    tick();
    mem_ack = 1'b0;
    set_port(2, 2'b00, 2'b00, 32'h0, 16'h0);

    // 3. All ports reading continuously (pointer now at port 2)
    for (int p = 0; p < NPORT; p++) begin
      set_port(p, 2'b10, 2'b00, 32'h100 * (p + 1), 16'h0);
    end
    for (int g = 0; g < 6; g++) begin
      exp_p = FIXED ? 0 : (g % NPORT);
      exp_v = 3'(1 << exp_p);
      tick();
      mem_ack = 1'b1;
      @(negedge clk);
      chk("t3_addr", mem_addr,     32'h100 * (exp_p + 1));
      chk("t3_ack",  32'(rq_ack),  32'(exp_v));
      tick();
      mem_ack = 1'b0;
      beats(4, exp_v, "t3");
    end
    rq_req = '0;
    tick();

    // 6. Port 1 re-requests right after its ack while port 2 is pending
    set_port(1, 2'b11, 2'b00, 32'h0000_0010, 16'h1111);
    set_port(2, 2'b11, 2'b00, 32'h0000_0020, 16'h2222);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t6_din1", 32'(mem_din), 32'h1111);
    chk("t6_ack1", 32'(rq_ack),  32'h2);
    tick();
    mem_ack = 1'b0;
    set_port(1, 2'b01, 2'b01, 32'h0000_0012, 16'h1212);
    @(negedge clk);
    chk("t6_gap", 32'(mem_req), 32'h0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t6_din2", 32'(mem_din), FIXED ? 32'h1212 : 32'h2222);
    chk("t6_ack2", 32'(rq_ack),  FIXED ? 32'h2 : 32'h4);
    tick();
    mem_ack = 1'b0;
    set_port(FIXED ? 1 : 2, 2'b00, 2'b00, 32'h0, 16'h0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t6_din3", 32'(mem_din), FIXED ? 32'h2222 : 32'h1212);
    chk("t6_ack3", 32'(rq_ack),  FIXED ? 32'h4 : 32'h2);
    tick();
    mem_ack = 1'b0;
    rq_req  = '0;
    tick();

    // 5. Reset during RDATA beat 2, then a fresh read
    set_port(0, 2'b10, 2'b00, 32'h0000_5000, 16'h0);
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    set_port(0, 2'b00, 2'b00, 32'h0, 16'h0);
    beats(2, 3'b001, "t5");
    mem_valid = 1'b1;
    mem_dout  = 16'hB002;
    reset     = 1'b1;
    @(negedge clk);
    chk("t5_b2", 32'(rq_valid), 32'h1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_req",   32'(mem_req),  32'h0);
    chk("t5_rst_valid", 32'(rq_valid), 32'h0);
    chk("t5_rst_addr",  mem_addr,      32'h0);
    tick();
    mem_valid = 1'b0;
    set_port(1, 2'b10, 2'b00, 32'h0000_6000, 16'h0);
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("t5_req",  32'(mem_req), 32'h2);
    chk("t5_addr", mem_addr,     32'h0000_6000);
    chk("t5_ack",  32'(rq_ack),  32'h2);
    tick();
    mem_ack = 1'b0;
    set_port(1, 2'b00, 2'b00, 32'h0, 16'h0);
    beats(4, 3'b010, "t5_fresh");
    probe_idle("t5_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
